// File: rtl/adder_checker.sv
// Response checker for the ripple-adder test setup: compares {c_out,s} against a+b+c_in,
// counts checks and mismatches, and captures the first failing tuple of each run.
module adder_checker #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 2**(2*WIDTH+1),
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   vec_valid,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   c_in,
  input  logic [WIDTH-1:0]       s,
  input  logic                   c_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2*WIDTH+1:0]     chk_count,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic [2*WIDTH:0]       first_err_vec,
  output logic [WIDTH:0]         first_err_exp,
  output logic [WIDTH:0]         first_err_got
);

  localparam int CNT_W = 2*WIDTH+2;
  localparam int VEC_W = 2*WIDTH+1;
  localparam int RES_W = WIDTH+1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [RES_W-1:0] exp;
    logic [RES_W-1:0] got;
  } err_rec_t;

  state_t               state_q, state_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     chk_count_q, chk_count_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  err_rec_t             first_err_q, first_err_d;

  logic [RES_W-1:0]     exp_sum;
  logic [RES_W-1:0]     got_sum;
  logic                 mismatch;
  logic [CNT_W-1:0]     chk_count_inc;

  // Full-width sum so the carry-out is compared, not truncated away.
  assign exp_sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  assign got_sum       = {c_out, s};
  assign mismatch      = (got_sum != exp_sum);
  assign chk_count_inc = chk_count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    chk_count_d = chk_count_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          chk_count_d = '0;
          err_count_d = '0;
          first_err_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          // abort discards any tuple presented in the same cycle
          state_d = DONE;
          done_d  = 1'b1;
        end else if (vec_valid) begin
          chk_count_d = chk_count_inc;
          if (mismatch) begin
            if (err_count_q != {ERR_CNT_W{1'b1}})
              err_count_d = err_count_q + ERR_CNT_W'(1);
            if (err_count_q == '0) begin
              first_err_d.vec = {a, b, c_in};
              first_err_d.exp = exp_sum;
              first_err_d.got = got_sum;
            end
          end
          if (chk_count_inc == CNT_W'(NUM_VECTORS)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      chk_count_q <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      chk_count_q <= chk_count_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = done_q;
  assign pass          = (state_q == DONE) && (err_count_q == '0) && (chk_count_q != '0);
  assign chk_count     = chk_count_q;
  assign err_count     = err_count_q;
  assign first_err_vec = first_err_q.vec;
  assign first_err_exp = first_err_q.exp;
  assign first_err_got = first_err_q.got;

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker: a table of run scenarios (fault, abort point, valid
// pattern) with hand-computed results, plus reset and idle-abort sequences.
module tb_adder_checker;

  logic        clk = 1'b0;
  logic        rst, start, abort, vec_valid, c_in, c_out;
  logic [3:0]  a, b, s;
  logic        busy, done, pass;
  logic [9:0]  chk_count;
  logic [15:0] err_count;
  logic [8:0]  first_err_vec;
  logic [4:0]  first_err_exp, first_err_got;

  int n_cmp = 0;
  int n_bad = 0;

  adder_checker #(.WIDTH(4), .NUM_VECTORS(512), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_valid(vec_valid),
    .a(a), .b(b), .c_in(c_in), .s(s), .c_out(c_out),
    .busy(busy), .done(done), .pass(pass), .chk_count(chk_count), .err_count(err_count),
    .first_err_vec(first_err_vec), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    fault;     // 0 correct, 1 flip s[0] at (3,5,1), 2 c_out stuck 0
    int    abort_at;  // vector index carrying abort, -1 for none
    bit    toggle;    // vec_valid 1/0 alternating plus a mid-run start
    int    exp_chk;
    int    exp_err;
    int    exp_vec;
    int    exp_exp;
    int    exp_got;
    bit    exp_pass;
  } scn_t;

  scn_t tbl[6];

  task automatic cmp(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive_vec(input int idx, input int fault);
    logic [8:0] v;
    logic [4:0] sum;
    v    = idx[8:0];
    a    = v[8:5];
    b    = v[4:1];
    c_in = v[0];
    sum  = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
    if (fault == 1 && v == 9'b0011_0101_1) sum[0] = ~sum[0];
    if (fault == 2) sum[4] = 1'b0;
    {c_out, s} = sum;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".busy"}, busy, 0);
    cmp({tag, ".done"}, done, 0);
    cmp({tag, ".pass"}, pass, 0);
    cmp({tag, ".chk"}, chk_count, 0);
    cmp({tag, ".err"}, err_count, 0);
    cmp({tag, ".vec"}, first_err_vec, 0);
    cmp({tag, ".exp"}, first_err_exp, 0);
    cmp({tag, ".got"}, first_err_got, 0);
  endtask

  // Starts a run at a negedge and feeds vectors until done is seen or the budget expires.
  task automatic run_scn(input scn_t r);
    int idx = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit fin = 0;
    bit track_ok = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp({r.name, ".busy_on_start"}, busy, 1);
    cmp({r.name, ".chk_cleared"}, chk_count, 0);
    while (!fin && cyc < 3000) begin
      drive_vec(idx, r.fault);
      vec_valid = r.toggle ? (cyc % 2 == 0) : 1'b1;
      abort     = (r.abort_at >= 0 && idx == r.abort_at);
      start     = r.toggle && (cyc == 51);
      @(negedge clk);
      if (vec_valid && !abort) idx++;
      if (abort) fin = 1;
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      if (chk_count != idx[9:0]) track_ok = 0;
      cyc++;
    end
    vec_valid = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: no done within 3000 cycles", r.name);
    end
    cmp({r.name, ".chk_tracks_valid"}, track_ok, 1);
    cmp({r.name, ".done_pulse"}, done_cnt, 1);
    cmp({r.name, ".busy_off"}, busy, 0);
    cmp({r.name, ".chk"}, chk_count, r.exp_chk);
    cmp({r.name, ".err"}, err_count, r.exp_err);
    cmp({r.name, ".pass"}, pass, r.exp_pass);
    if (r.exp_err != 0) begin
      cmp({r.name, ".first_vec"}, first_err_vec, r.exp_vec);
      cmp({r.name, ".first_exp"}, first_err_exp, r.exp_exp);
      cmp({r.name, ".first_got"}, first_err_got, r.exp_got);
    end
    drive_vec(0, 0);
    vec_valid = 1'b1;
    @(negedge clk);
    cmp({r.name, ".done_one_cycle"}, done, 0);
    cmp({r.name, ".chk_held"}, chk_count, r.exp_chk);
    cmp({r.name, ".pass_held"}, pass, r.exp_pass);
    vec_valid = 1'b0;
  endtask

  initial begin
    // name fault abort toggle chk err vec exp got pass
    tbl[0] = '{"sweep_ok",   0, -1, 0, 512,   0, 0,       0,  0, 1};
    tbl[1] = '{"flip_s0",    1, -1, 0, 512,   1, 9'h06B,  9,  8, 0};
    tbl[2] = '{"cout_stuck", 2, -1, 0, 512, 256, 9'h01F, 16,  0, 0};
    tbl[3] = '{"abort_100",  0, 100, 0, 100,  0, 0,       0,  0, 1};
    tbl[4] = '{"abort_40_f", 2, 40, 0,  40,   1, 9'h01F, 16,  0, 0};
    tbl[5] = '{"toggle",     0, -1, 1, 512,   0, 0,       0,  0, 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; vec_valid = 1'b0;
    drive_vec(0, 0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // abort and vec_valid in IDLE are ignored
    abort = 1'b1; vec_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; vec_valid = 1'b0;
    check_zero("idle_abort");

    for (int i = 0; i < 6; i++) run_scn(tbl[i]);

    // reset mid-run after 300 vectors, with start held to show rst wins
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive_vec(i, 2);
      vec_valid = 1'b1;
      @(negedge clk);
    end
    cmp("mid.chk_before_rst", chk_count, 300);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; vec_valid = 1'b0;
    check_zero("mid_rst");
    run_scn(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
